// File: rtl/timer_driver_if.sv
// timer_driver_if: host command and capture-response channels of the timer driver
interface timer_driver_if;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [1:0]  cmd_op_in;
  logic [31:0] cmd_data_in;
  logic        rsp_valid_out;
  logic        rsp_ready_in;
  logic [31:0] rsp_data_out;
  modport master (
    output cmd_valid_in, cmd_op_in, cmd_data_in, rsp_ready_in,
    input  cmd_ready_out, rsp_valid_out, rsp_data_out
  );
  modport slave (
    input  cmd_valid_in, cmd_op_in, cmd_data_in, rsp_ready_in,
    output cmd_ready_out, rsp_valid_out, rsp_data_out
  );
endinterface

// File: rtl/timer_driver.sv
// timer_driver: turns host commands into timer strobes, reads back captures, raises a sticky alarm irq
module timer_driver #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int CAPT_LAT     = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  timer_driver_if.slave bus,
  output logic        start_out,
  output logic        capture_out,
  output logic        rst_capture_out,
  output logic        alarm_en_out,
  output logic [31:0] alarm_value_out,
  input  logic [31:0] captured_in,
  input  logic        alarm_flag_in,
  output logic        alarm_irq_out
);
  typedef enum logic [2:0] {IDLE, PULSE_HI, PULSE_LO, WAIT_CAPT, RESP} state_t;
  localparam logic [1:0] OP_START = 2'b00, OP_CAPT = 2'b01, OP_CLR = 2'b10, OP_SET = 2'b11;
  localparam logic [7:0] P_LD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] G_LD = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] C_LD = 8'(CAPT_LAT - 1);
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_op;
  logic       r_flag, r_flag_d;
  logic       w_accept, w_set, w_rise;
  assign w_accept = bus.cmd_valid_in & bus.cmd_ready_out;
  assign w_set    = w_accept & (bus.cmd_op_in == OP_SET);
  assign w_rise   = r_flag & ~r_flag_d;
  // Command FSM: one down-counter times strobe high, forced gap and capture latency
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state           <= IDLE;
      r_cnt             <= '0;
      r_op              <= OP_START;
      bus.cmd_ready_out <= 1'b1;
      bus.rsp_valid_out <= 1'b0;
      bus.rsp_data_out  <= '0;
      start_out         <= 1'b0;
      capture_out       <= 1'b0;
      rst_capture_out   <= 1'b0;
      alarm_en_out      <= 1'b0;
      alarm_value_out   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          if (bus.cmd_op_in == OP_SET) begin
            alarm_value_out <= bus.cmd_data_in;
            alarm_en_out    <= bus.cmd_data_in != 0;
          end else begin
            r_op              <= bus.cmd_op_in;
            r_state           <= PULSE_HI;
            r_cnt             <= P_LD;
            bus.cmd_ready_out <= 1'b0;
            start_out         <= bus.cmd_op_in == OP_START;
            capture_out       <= bus.cmd_op_in == OP_CAPT;
            rst_capture_out   <= bus.cmd_op_in == OP_CLR;
          end
        end
        PULSE_HI: if (r_cnt == 0) begin
          start_out       <= 1'b0;
          capture_out     <= 1'b0;
          rst_capture_out <= 1'b0;
          r_state         <= PULSE_LO;
          r_cnt           <= G_LD;
        end else r_cnt <= r_cnt - 8'd1;
        PULSE_LO: if (r_cnt == 0) begin
          if (r_op == OP_CAPT) begin
            r_state <= WAIT_CAPT;
            r_cnt   <= C_LD;
          end else begin
            r_state           <= IDLE;
            bus.cmd_ready_out <= 1'b1;
          end
        end else r_cnt <= r_cnt - 8'd1;
        WAIT_CAPT: if (r_cnt == 0) begin
          r_state           <= RESP;
          bus.rsp_data_out  <= captured_in;
          bus.rsp_valid_out <= 1'b1;
        end else r_cnt <= r_cnt - 8'd1;
        RESP: if (bus.rsp_ready_in) begin
          bus.rsp_valid_out <= 1'b0;
          r_state           <= IDLE;
          bus.cmd_ready_out <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // Alarm irq: registered flag edge sets it (winning over a clear), SET_ALARM clears it
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_flag        <= 1'b0;
      r_flag_d      <= 1'b0;
      alarm_irq_out <= 1'b0;
    end else begin
      r_flag        <= alarm_flag_in;
      r_flag_d      <= r_flag;
      alarm_irq_out <= w_rise | (alarm_irq_out & ~w_set);
    end
  end
endmodule

// File: tb/tb_timer_driver.sv
// tb_timer_driver: directed vectors with a response scoreboard for timer_driver
module tb_timer_driver;
  logic        clk = 1'b0, rst = 1'b1;
  logic        start, capture, rst_capture, alarm_en, irq, flag = 1'b0;
  logic [31:0] alarm_value, captured = '0;
  int          n_vec = 0, n_err = 0;
  logic [31:0] exp_q[$];
  timer_driver_if bus();
  timer_driver dut (
    .clk_in(clk), .rst_in(rst), .bus(bus.slave),
    .start_out(start), .capture_out(capture), .rst_capture_out(rst_capture),
    .alarm_en_out(alarm_en), .alarm_value_out(alarm_value),
    .captured_in(captured), .alarm_flag_in(flag), .alarm_irq_out(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input logic [1:0] op, input logic [31:0] data);
    bus.cmd_valid_in = 1'b1;
    bus.cmd_op_in    = op;
    bus.cmd_data_in  = data;
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_ready"}, {31'b0, bus.cmd_ready_out}, 1);
    chk({tag, "_strobes"}, {29'b0, start, capture, rst_capture}, 0);
    chk({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid_out}, 0);
  endtask
  // Scoreboard monitor: every response handshake pops one expected capture value
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid_out && bus.rsp_ready_in) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got %h expected no response", bus.rsp_data_out);
      end else chk("rsp_data", bus.rsp_data_out, exp_q.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [2:0] st_exp;
    bus.cmd_valid_in = 1'b0;
    bus.cmd_op_in    = 2'b00;
    bus.cmd_data_in  = '0;
    bus.rsp_ready_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    idle_chk("reset");
    chk("reset_alarm", {alarm_value[30:0], alarm_en}, 0);
    chk("reset_irq", {31'b0, irq}, 0);
    // 1: START strobe shape and ready return
    cmd(2'b00, 0);
    st_exp = 3'b110;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.cmd_valid_in = 1'b0;
      chk($sformatf("start_e%0d", i), {30'b0, start, bus.cmd_ready_out}, i < 2 ? 2'b10 : (i == 4 ? 2'b01 : 2'b00));
      chk($sformatf("start_others_e%0d", i), {30'b0, capture, rst_capture}, 0);
    end
    // 2: CAPTURE with held response
    captured = 32'h0000_1234;
    cmd(2'b01, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.cmd_valid_in = 1'b0;
      chk($sformatf("capt_e%0d", i), {30'b0, capture, bus.rsp_valid_out}, i < 2 ? 2'b10 : (i == 7 ? 2'b01 : 2'b00));
    end
    chk("capt_data", bus.rsp_data_out, 32'h1234);
    captured = 32'hDEAD_BEEF;
    exp_q.push_back(32'h1234);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("capt_hold", {bus.rsp_valid_out, bus.rsp_data_out[30:0]}, {1'b1, 31'h1234});
    end
    bus.rsp_ready_in = 1'b1;
    tick();
    bus.rsp_ready_in = 1'b0;
    idle_chk("capt_done");
    // 3: back-to-back SET_ALARM
    cmd(2'b11, 32'h64);
    tick();
    chk("set1", {alarm_value[30:0], alarm_en}, {31'h64, 1'b1});
    chk("set1_ready", {31'b0, bus.cmd_ready_out}, 1);
    cmd(2'b11, 0);
    tick();
    bus.cmd_valid_in = 1'b0;
    chk("set0", {alarm_value[30:0], alarm_en}, 0);
    chk("set0_ready", {31'b0, bus.cmd_ready_out}, 1);
    // 4: sticky alarm interrupt
    flag = 1'b1;
    tick();
    chk("irq_e1", {31'b0, irq}, 0);
    tick();
    chk("irq_e2", {31'b0, irq}, 1);
    cmd(2'b11, 32'h10);
    tick();
    bus.cmd_valid_in = 1'b0;
    chk("irq_clr", {31'b0, irq}, 0);
    chk("irq_clr_val", alarm_value, 32'h10);
    tick(); tick(); tick();
    chk("irq_level_no_reset", {31'b0, irq}, 0);
    flag = 1'b0;
    tick(); tick(); tick();
    flag = 1'b1;
    tick();
    cmd(2'b11, 32'h20);
    tick();
    bus.cmd_valid_in = 1'b0;
    chk("irq_set_wins", {31'b0, irq}, 1);
    chk("irq_set_wins_val", alarm_value, 32'h20);
    // 5: command while busy is ignored
    captured = 32'h0000_CAFE;
    cmd(2'b01, 0);
    tick();
    bus.cmd_valid_in = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    cmd(2'b10, 0);
    for (int i = 5; i < 7; i++) begin
      tick();
      chk("busy_ready", {30'b0, bus.cmd_ready_out, rst_capture}, 0);
    end
    bus.cmd_valid_in = 1'b0;
    tick();
    chk("busy_rsp_valid", {31'b0, bus.rsp_valid_out}, 1);
    chk("busy_rsp_data", bus.rsp_data_out, 32'hCAFE);
    chk("busy_no_clr", {31'b0, rst_capture}, 0);
    exp_q.push_back(32'hCAFE);
    bus.rsp_ready_in = 1'b1;
    tick();
    bus.rsp_ready_in = 1'b0;
    idle_chk("busy_done");
    // 6: reset mid-strobe and mid-response
    cmd(2'b01, 0);
    tick();
    bus.cmd_valid_in = 1'b0;
    chk("rst_pre_capt", {31'b0, capture}, 1);
    rst = 1'b1;
    tick();
    chk("rst_capt_drop", {29'b0, start, capture, rst_capture}, 0);
    rst = 1'b0;
    tick();
    idle_chk("rst1_release");
    chk("rst_irq", {31'b0, irq}, 0);
    cmd(2'b01, 0);
    tick();
    bus.cmd_valid_in = 1'b0;
    begin
      int n = 0;
      while (!bus.rsp_valid_out && n < 20) begin
        tick();
        n++;
      end
      chk("rst_resp_reached", {31'b0, bus.rsp_valid_out}, 1);
    end
    rst = 1'b1;
    tick();
    chk("rst_rsp_drop", {31'b0, bus.rsp_valid_out}, 0);
    rst = 1'b0;
    tick();
    idle_chk("rst2_release");
    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
